// File: rtl/mem_lsu.sv
// MEM-stage load/store unit.
// Takes the effective address and store data from EX/MEM and issues one
// request/acknowledge access at a time on the data-memory port. It returns
// sign/zero-extended load data toward MEM/WB and stalls the front of the
// pipeline while an access is in flight. Misaligned accesses are dropped
// with a one-cycle flag. Accesses that see no acknowledge are aborted after
// TIMEOUT cycles with a one-cycle bus error.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_st_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last counter value still allowed in BUSY before the abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic        we_r;
    logic        is_ld_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [31:0] ld_data_r;

    logic        f3_ok_s;
    logic        mis_addr_s;
    logic        launch_req_s;
    logic        misal_s;
    logic        launch_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Pick the addressed byte/half out of the returned word and extend it.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b010:  extend_load = word;
            3'b100:  extend_load = {24'h000000, b};
            3'b101:  extend_load = {16'h0000, h};
            default: extend_load = 32'h0000_0000;
        endcase
    endfunction

    // Decode the EX/MEM instruction: legality, alignment, lanes and enables.
    always_comb begin
        f3_ok_s    = 1'b0;
        mis_addr_s = 1'b0;
        be_s       = 4'b0000;
        wdata_s    = 32'h0000_0000;

        if (i_mem_rd) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
                default:                                f3_ok_s = 1'b0;
            endcase
        end else begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
                default:                f3_ok_s = 1'b0;
            endcase
        end

        case (i_funct3[1:0])
            2'b01:   mis_addr_s = i_alu_data[0];
            2'b10:   mis_addr_s = |i_alu_data[1:0];
            default: mis_addr_s = 1'b0;
        endcase

        if (i_mem_rd) begin
            be_s    = 4'b1111;
            wdata_s = 32'h0000_0000;
        end else begin
            case (i_funct3[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << i_alu_data[1:0];
                    wdata_s = {4{i_st_data[7:0]}};
                end
                2'b01: begin
                    be_s    = i_alu_data[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{i_st_data[15:0]}};
                end
                2'b10: begin
                    be_s    = 4'b1111;
                    wdata_s = i_st_data;
                end
                default: begin
                    be_s    = 4'b0000;
                    wdata_s = 32'h0000_0000;
                end
            endcase
        end
    end

    // A launch needs exactly one of rd/wr and a supported size; reset blocks it.
    assign launch_req_s = ~i_rst & i_valid & (i_mem_rd ^ i_mem_wr) & f3_ok_s;
    assign misal_s      = launch_req_s & mis_addr_s;
    assign launch_s     = launch_req_s & ~mis_addr_s;

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_dmem_ack) begin
                    state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Stall and misalignment react in the launch cycle, so they stay combinational.
    always_comb begin
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        case (state_r)
            ST_IDLE: begin
                o_stall      = launch_s;
                o_misaligned = misal_s;
            end
            ST_BUSY: begin
                o_stall      = 1'b1;
                o_misaligned = 1'b0;
            end
            default: begin
                o_stall      = 1'b0;
                o_misaligned = 1'b0;
            end
        endcase
    end

    // State, timeout counter, latched request fields and load result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            be_r      <= 4'b0000;
            we_r      <= 1'b0;
            is_ld_r   <= 1'b0;
            funct3_r  <= 3'b000;
            off_r     <= 2'b00;
            ld_data_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= 8'd0;
                    ld_data_r <= 32'h0000_0000;
                    if (launch_s) begin
                        addr_r   <= {i_alu_data[31:2], 2'b00};
                        wdata_r  <= wdata_s;
                        be_r     <= be_s;
                        we_r     <= i_mem_wr;
                        is_ld_r  <= i_mem_rd;
                        funct3_r <= i_funct3;
                        off_r    <= i_alu_data[1:0];
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (i_dmem_ack) begin
                        ld_data_r <= is_ld_r ? extend_load(funct3_r, off_r, i_dmem_rdata)
                                             : 32'h0000_0000;
                    end
                end
                default: begin
                    cnt_r     <= 8'd0;
                    ld_data_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign o_dmem_req   = (state_r == ST_BUSY);
    assign o_dmem_we    = we_r;
    assign o_dmem_addr  = addr_r;
    assign o_dmem_wdata = wdata_r;
    assign o_dmem_be    = be_r;
    assign o_ld_data    = ld_data_r;
    assign o_ld_valid   = ((state_r == ST_DONE) || (state_r == ST_ERR)) && is_ld_r;
    assign o_bus_err    = (state_r == ST_ERR);

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios with literal
// expectations followed by randomized traffic against a transaction model.
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_data;
    logic [31:0] i_st_data;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_ld_data;
    logic        o_ld_valid;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_err;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_mem_rd     (i_mem_rd),
        .i_mem_wr     (i_mem_wr),
        .i_funct3     (i_funct3),
        .i_alu_data   (i_alu_data),
        .i_st_data    (i_st_data),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_be    (o_dmem_be),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_ld_data    (o_ld_data),
        .o_ld_valid   (o_ld_valid),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err)
    );

    typedef struct {
        int        id;
        bit        valid;
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] st;
        int        delay;
        int        rst_at;
        bit        force_en;
        bit [31:0] force_rd;
        bit        lit;
        int        e_req;
        int        e_stall;
        int        e_ldv;
        bit [31:0] e_ld;
        int        e_mis;
        int        e_err;
        bit [31:0] e_addr;
        bit [3:0]  e_be;
        bit [31:0] e_wdata;
    } op_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state (owned by the compare process).
    int        m_state = 0;  // 0 idle, 1 waiting on memory, 2 completed, 3 aborted
    int        m_cnt   = 0;
    bit        m_ld    = 1'b0;
    bit        m_we    = 1'b0;
    bit [2:0]  m_f3    = 3'b000;
    bit [31:0] m_addr  = 32'h0;
    bit [31:0] m_baddr = 32'h0;
    bit [31:0] m_wdata = 32'h0;
    bit [3:0]  m_be    = 4'h0;
    bit [31:0] m_ld_data = 32'h0;
    bit        m_stall_last = 1'b0;
    bit        m_rst_prev   = 1'b0;

    // Per-operation observations for the literal checks.
    int        obs_req, obs_stall, obs_ldv, obs_mis, obs_err;
    bit [31:0] obs_ld, obs_addr, obs_wdata;
    bit [3:0]  obs_be;

    bit [31:0] mem [bit [31:0]];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int size_of(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit f3_legal(input bit rd, input bit [2:0] f3);
        if (rd) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    endfunction

    function automatic bit [31:0] ld_value(input bit [2:0] f3, input bit [31:0] baddr, input bit [31:0] word);
        int        sz;
        bit [31:0] v;
        bit [31:0] mask;
        sz   = size_of(f3);
        v    = word >> (8 * (baddr & 32'd3));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit [31:0] mem_read(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        else               return a ^ 32'h5A5A_A5A5;
    endfunction

    // Compare process: checks every cycle, then advances the model.
    bit        c_legal, c_mis, c_launch;
    bit        e_req, e_stall, e_misf, e_ldv, e_err;
    bit [31:0] e_ld;
    int        c_sz;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            c_legal  = !i_rst && i_valid && (i_mem_rd ^ i_mem_wr) && f3_legal(i_mem_rd, i_funct3);
            c_sz     = size_of(i_funct3);
            c_mis    = c_legal && ((i_alu_data % c_sz) != 0);
            c_launch = c_legal && !c_mis;
            e_req    = (m_state == 1);
            e_stall  = (m_state == 1) || (m_state == 0 && c_launch);
            e_misf   = (m_state == 0) && c_mis;
            e_ldv    = (m_state == 2 || m_state == 3) && m_ld;
            e_ld     = (m_state == 2) ? m_ld_data : 32'h0;
            e_err    = (m_state == 3);

            check32("req", {31'b0, o_dmem_req}, {31'b0, e_req});
            check32("stall", {31'b0, o_stall}, {31'b0, e_stall});
            check32("misaligned", {31'b0, o_misaligned}, {31'b0, e_misf});
            check32("ld_valid", {31'b0, o_ld_valid}, {31'b0, e_ldv});
            check32("ld_data", o_ld_data, e_ld);
            check32("bus_err", {31'b0, o_bus_err}, {31'b0, e_err});
            if (e_req) begin
                check32("dmem_addr", o_dmem_addr, m_addr);
                check32("dmem_we", {31'b0, o_dmem_we}, {31'b0, m_we});
                check32("dmem_be", {28'b0, o_dmem_be}, {28'b0, m_be});
                if (m_we) check32("dmem_wdata", o_dmem_wdata, m_wdata);
            end
            if (m_rst_prev) begin
                check32("rst_addr", o_dmem_addr, 32'h0);
                check32("rst_wdata", o_dmem_wdata, 32'h0);
                check32("rst_be_we", {27'b0, o_dmem_be, o_dmem_we}, 32'h0);
            end

            if (o_dmem_req) begin
                obs_req++;
                obs_addr  = o_dmem_addr;
                obs_be    = o_dmem_be;
                obs_wdata = o_dmem_wdata;
            end
            if (o_stall) obs_stall++;
            if (o_ld_valid) begin
                obs_ldv++;
                obs_ld = o_ld_data;
            end
            if (o_misaligned) obs_mis++;
            if (o_bus_err) obs_err++;

            m_stall_last = e_stall;
            m_rst_prev   = i_rst;
            if (i_rst) begin
                m_state = 0; m_cnt = 0; m_ld = 0; m_we = 0; m_ld_data = 32'h0;
            end else if (m_state == 0) begin
                if (c_launch) begin
                    m_state = 1;
                    m_cnt   = 0;
                    m_ld    = i_mem_rd;
                    m_we    = i_mem_wr;
                    m_f3    = i_funct3;
                    m_baddr = i_alu_data;
                    m_addr  = i_alu_data & 32'hFFFF_FFFC;
                    m_be    = i_mem_rd ? 4'hF : 4'(((1 << c_sz) - 1) << (i_alu_data & 32'd3));
                    m_wdata = (c_sz == 1) ? i_st_data[7:0] * 32'h0101_0101 :
                              (c_sz == 2) ? i_st_data[15:0] * 32'h0001_0001 : i_st_data;
                end
            end else if (m_state == 1) begin
                if (i_dmem_ack) begin
                    m_ld_data = m_ld ? ld_value(m_f3, m_baddr, i_dmem_rdata) : 32'h0;
                    m_state   = 2;
                end else if (m_cnt == TO - 1) begin
                    m_state = 3;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_state = 0; m_cnt = 0; m_ld_data = 32'h0;
            end
        end
    end

    function automatic op_t mk(input int id, input bit rd, input bit wr, input bit [2:0] f3,
                               input bit [31:0] addr, input bit [31:0] st, input int delay,
                               input int rst_at, input bit fe, input bit [31:0] frd);
        op_t o;
        o = '{default: 0};
        o.id = id; o.valid = 1'b1; o.rd = rd; o.wr = wr; o.f3 = f3; o.addr = addr; o.st = st;
        o.delay = delay; o.rst_at = rst_at; o.force_en = fe; o.force_rd = frd;
        return o;
    endfunction

    function automatic op_t with_exp(input op_t oi, input int req, input int stall, input int ldv,
                                     input bit [31:0] ld, input int mis, input int err,
                                     input bit [31:0] a, input bit [3:0] be, input bit [31:0] wd);
        op_t o;
        o = oi;
        o.lit = 1'b1; o.e_req = req; o.e_stall = stall; o.e_ldv = ldv; o.e_ld = ld;
        o.e_mis = mis; o.e_err = err; o.e_addr = a; o.e_be = be; o.e_wdata = wd;
        return o;
    endfunction

    function automatic op_t rand_op(input int id);
        op_t o;
        int  sel;
        int  k;
        o = '{default: 0};
        o.id    = id;
        o.valid = ($urandom_range(0, 9) != 0);
        sel     = int'($urandom_range(0, 9));
        o.rd    = (sel == 0) || (sel >= 2 && sel <= 5);
        o.wr    = (sel == 0) || (sel >= 6);
        if ($urandom_range(0, 4) == 0) begin
            o.f3 = 3'($urandom_range(0, 7));
        end else if (o.rd) begin
            k    = int'($urandom_range(0, 4));
            o.f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        end else begin
            o.f3 = 3'($urandom_range(0, 2));
        end
        o.addr   = (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 31));
        o.st     = $urandom;
        o.delay  = int'($urandom_range(0, TO));
        o.rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, TO - 1)) : 255;
        return o;
    endfunction

    task automatic lit_check(input op_t o);
        check32($sformatf("op%0d_req_cycles", o.id), obs_req, o.e_req);
        check32($sformatf("op%0d_stall_cycles", o.id), obs_stall, o.e_stall);
        check32($sformatf("op%0d_ldv_pulses", o.id), obs_ldv, o.e_ldv);
        check32($sformatf("op%0d_mis_pulses", o.id), obs_mis, o.e_mis);
        check32($sformatf("op%0d_err_pulses", o.id), obs_err, o.e_err);
        if (o.e_ldv > 0) check32($sformatf("op%0d_ld_data", o.id), obs_ld, o.e_ld);
        if (o.e_req > 0) begin
            check32($sformatf("op%0d_addr", o.id), obs_addr, o.e_addr);
            check32($sformatf("op%0d_be", o.id), {28'b0, obs_be}, {28'b0, o.e_be});
            if (o.wr) check32($sformatf("op%0d_wdata", o.id), obs_wdata, o.e_wdata);
        end
    endtask

    // Stimulus: one instruction per pipeline advance, memory responder driven from the model.
    op_t dq[$];
    op_t cur;
    bit  late_ack;
    bit  all_done;
    int  rand_left;
    int  next_id;
    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_funct3 = 3'b000;
        i_alu_data = 32'h0; i_st_data = 32'h0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
        cur = '{default: 0};
        cur.delay = 255; cur.rst_at = 255;
        late_ack = 1'b0; all_done = 1'b0; rand_left = 400; next_id = 100;
        obs_req = 0; obs_stall = 0; obs_ldv = 0; obs_mis = 0; obs_err = 0;

        dq.push_back(with_exp(mk(1, 0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 1, 255, 0, 0),
                              2, 3, 0, 0, 0, 0, 32'h1000, 4'b1000, 32'hA5A5_A5A5));
        dq.push_back(with_exp(mk(2, 1, 0, 3'b000, 32'h2002, 0, 0, 255, 1, 32'h12F0_3456),
                              1, 2, 1, 32'hFFFF_FFF0, 0, 0, 32'h2000, 4'b1111, 0));
        dq.push_back(with_exp(mk(3, 1, 0, 3'b100, 32'h2002, 0, 0, 255, 1, 32'h12F0_3456),
                              1, 2, 1, 32'h0000_00F0, 0, 0, 32'h2000, 4'b1111, 0));
        dq.push_back(with_exp(mk(4, 1, 0, 3'b001, 32'h2002, 0, 0, 255, 1, 32'h8001_0000),
                              1, 2, 1, 32'hFFFF_8001, 0, 0, 32'h2000, 4'b1111, 0));
        dq.push_back(with_exp(mk(5, 1, 0, 3'b010, 32'h3001, 0, 0, 255, 0, 0),
                              0, 0, 0, 0, 1, 0, 0, 0, 0));
        dq.push_back(with_exp(mk(6, 1, 0, 3'b010, 32'h0040, 0, 255, 255, 0, 0),
                              4, 5, 1, 32'h0, 0, 1, 32'h0040, 4'b1111, 0));
        dq.push_back(with_exp(mk(7, 1, 0, 3'b010, 32'h0044, 0, 0, 255, 1, 32'h1122_3344),
                              1, 2, 1, 32'h1122_3344, 0, 0, 32'h0044, 4'b1111, 0));
        dq.push_back(with_exp(mk(8, 1, 0, 3'b010, 32'h2000, 0, 255, 1, 0, 0),
                              2, 3, 0, 0, 0, 0, 32'h2000, 4'b1111, 0));
        dq.push_back(with_exp(mk(9, 0, 1, 3'b001, 32'h1006, 32'h0000_BEEF, 2, 255, 0, 0),
                              3, 4, 0, 0, 0, 0, 32'h1004, 4'b1100, 32'hBEEF_BEEF));
        dq.push_back(with_exp(mk(10, 0, 1, 3'b010, 32'h0010, 32'hDEAD_BEEF, 0, 255, 0, 0),
                              1, 2, 0, 0, 0, 0, 32'h0010, 4'b1111, 32'hDEAD_BEEF));
        dq.push_back(with_exp(mk(11, 1, 0, 3'b010, 32'h0010, 0, 0, 255, 0, 0),
                              1, 2, 1, 32'hDEAD_BEEF, 0, 0, 32'h0010, 4'b1111, 0));
        dq.push_back(with_exp(mk(12, 1, 1, 3'b010, 32'h0020, 0, 0, 255, 0, 0),
                              0, 0, 0, 0, 0, 0, 0, 0, 0));
        dq.push_back(with_exp(mk(13, 1, 0, 3'b011, 32'h0020, 0, 0, 255, 0, 0),
                              0, 0, 0, 0, 0, 0, 0, 0, 0));
        dq.push_back(with_exp(mk(14, 1, 0, 3'b101, 32'h2002, 0, 1, 255, 1, 32'h8001_0000),
                              2, 3, 1, 32'h0000_8001, 0, 0, 32'h2000, 4'b1111, 0));

        @(negedge clk);
        for (int cyc = 0; cyc < 20000 && !all_done; cyc++) begin
            @(negedge clk);
            if (!m_stall_last && !late_ack) begin
                if (cur.lit) lit_check(cur);
                if (dq.size() > 0) begin
                    cur = dq.pop_front();
                end else if (rand_left > 0) begin
                    cur = rand_op(next_id);
                    next_id++;
                    rand_left--;
                end else begin
                    cur = '{default: 0};
                    cur.delay = 255; cur.rst_at = 255;
                    all_done = 1'b1;
                end
                obs_req = 0; obs_stall = 0; obs_ldv = 0; obs_mis = 0; obs_err = 0;
            end
            i_rst        = 1'b0;
            i_dmem_ack   = 1'b0;
            i_dmem_rdata = $urandom;
            if (late_ack) begin
                i_dmem_ack = 1'b1;
                late_ack   = 1'b0;
            end else if (m_state == 1) begin
                if (m_cnt == cur.rst_at) begin
                    i_rst     = 1'b1;
                    cur.valid = 1'b0;
                    late_ack  = 1'b1;
                end else if (m_cnt == cur.delay) begin
                    i_dmem_ack = 1'b1;
                    if (m_we) begin
                        for (int b = 0; b < 4; b++) begin
                            bit [31:0] w;
                            w = mem_read(m_addr);
                            if (m_be[b]) w[8 * b +: 8] = m_wdata[8 * b +: 8];
                            mem[m_addr] = w;
                        end
                    end else begin
                        i_dmem_rdata = cur.force_en ? cur.force_rd : mem_read(m_addr);
                    end
                end
            end
            i_valid    = cur.valid;
            i_mem_rd   = cur.rd;
            i_mem_wr   = cur.wr;
            i_funct3   = cur.f3;
            i_alu_data = cur.addr;
            i_st_data  = cur.st;
        end
        if (!all_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL cycle_budget: stimulus not finished, %0d ops left", dq.size() + rand_left);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
